// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
// The state encoding and the signed-overflow rule are defined here.
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement overflow: the operand signs agree and the sum sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiword_add_seq.sv
// Feeds a W = N*WORDS bit add/subtract through one external N-bit adder,
// one word per cycle (LSW first), and chains the carry between words.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] op_a,
    input  logic [N*WORDS-1:0] op_b,
    input  logic               op_cin,
    input  logic               op_sub,
    output logic [N-1:0]       add_a,
    output logic [N-1:0]       add_b,
    output logic               add_cin,
    input  logic [N-1:0]       add_s,
    input  logic               add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] res,
    output logic               res_cout,
    output logic               res_ovf
);

    localparam int W  = N * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    if (N < 1 || WORDS < 1) begin : g_bad_params
        $error("multiword_add_seq: N and WORDS must both be >= 1");
    end

    state_e        state_r;
    state_e        state_s;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  res_r;
    logic          carry_r;
    logic          ovf_r;
    logic [KW-1:0] k_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: accept only from IDLE, so a DONE->IDLE handshake never overlaps an accept.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (k_r == K_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Adder drive: the current word in RUN, quiet zeros otherwise.
    always_comb begin
        add_a   = {N{1'b0}};
        add_b   = {N{1'b0}};
        add_cin = 1'b0;
        if (state_r == RUN) begin
            add_a   = a_r[int'(k_r) * N +: N];
            add_b   = b_r[int'(k_r) * N +: N];
            add_cin = carry_r;
        end else begin
            add_a   = {N{1'b0}};
            add_b   = {N{1'b0}};
            add_cin = 1'b0;
        end
    end

    // Operand capture and word-serial accumulation; subtraction is A + ~B + ~borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            res_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            k_r     <= {KW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= op_a;
                        b_r     <= op_sub ? ~op_b : op_b;
                        carry_r <= op_sub ? ~op_cin : op_cin;
                        k_r     <= {KW{1'b0}};
                    end
                end
                RUN: begin
                    res_r[int'(k_r) * N +: N] <= add_s;
                    carry_r                   <= add_cout;
                    k_r                       <= k_r + KW'(1);
                    if (k_r == K_LAST) begin
                        ovf_r <= signed_ovf(a_r[W-1], b_r[W-1], add_s[N-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) && rst_n;
    assign out_valid = (state_r == DONE);
    assign res       = res_r;
    assign res_cout  = carry_r;
    assign res_ovf   = ovf_r;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed-vector and random bench for multiword_add_seq (N=8 with WORDS=4 and WORDS=1).
module tb_multiword_add_seq;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // WORDS=4 instance
    logic        in_valid, in_ready, op_cin, op_sub, out_valid, out_ready;
    logic [31:0] op_a, op_b, res;
    logic [7:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout, res_cout, res_ovf;

    // WORDS=1 instance
    logic        u_in_valid, u_in_ready, u_op_cin, u_op_sub, u_out_valid, u_out_ready;
    logic [7:0]  u_op_a, u_op_b, u_res;
    logic [7:0]  u_add_a, u_add_b, u_add_s;
    logic        u_add_cin, u_add_cout, u_res_cout, u_res_ovf;

    assign {add_cout, add_s}     = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
    assign {u_add_cout, u_add_s} = {1'b0, u_add_a} + {1'b0, u_add_b} + {8'd0, u_add_cin};

    multiword_add_seq #(.N(N), .WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .res_cout(res_cout), .res_ovf(res_ovf)
    );

    multiword_add_seq #(.N(N), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .op_a(u_op_a), .op_b(u_op_b), .op_cin(u_op_cin), .op_sub(u_op_sub),
        .add_a(u_add_a), .add_b(u_add_b), .add_cin(u_add_cin), .add_s(u_add_s), .add_cout(u_add_cout),
        .out_valid(u_out_valid), .out_ready(u_out_ready),
        .res(u_res), .res_cout(u_res_cout), .res_ovf(u_res_ovf)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_res;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Golden model of a w-bit add/subtract with raw carry and signed overflow.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                  input logic sub, input int w,
                                  output logic [31:0] r, output logic c, output logic o);
        longint mask, ua, ub, ci, sa, sb, v, s;
        mask = (longint'(1) << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        ci = cin ? 1 : 0;
        if (sub) begin
            r = 32'((ua - ub - ci) & mask);
            c = (ua >= ub + ci);
        end else begin
            s = ua + ub + ci;
            r = 32'(s & mask);
            c = ((s >> w) & 1) == 1;
        end
        sa = a[w-1] ? ua - (longint'(1) << w) : ua;
        sb = b[w-1] ? ub - (longint'(1) << w) : ub;
        v  = sub ? (sa - sb - ci) : (sa + sb + ci);
        o  = (v > (longint'(1) << (w - 1)) - 1) || (v < -(longint'(1) << (w - 1)));
    endfunction

    task automatic issue4(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int n;
        @(negedge clk);
        op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect4(output logic [31:0] r, output logic c, output logic o,
                            output int lat, output logic [31:0] seq);
        lat = 0;
        seq = 32'd0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) seq[lat*8 +: 8] = add_a;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = res; c = res_cout; o = res_ovf;
    endtask

    task automatic release4(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", {63'd0, out_valid}, 64'd0);
        chk("ready_back", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        vec_t        vecs[9];
        logic [31:0] r, seq, er;
        logic        c, o, ec, eo;
        int          lat, n;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
        vecs[6] = '{32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b0};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[8] = '{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0};

        rst_n = 1'b1;
        in_valid = 1'b0; op_a = 32'd0; op_b = 32'd0; op_cin = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
        u_in_valid = 1'b0; u_op_a = 8'd0; u_op_b = 8'd0; u_op_cin = 1'b0; u_op_sub = 1'b0; u_out_ready = 1'b0;

        // Reset asserted mid-cycle, outputs checked before the next edge
        #12 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_res", {32'd0, res}, 64'd0);
        chk("rst_cout_ovf", {62'd0, res_cout, res_ovf}, 64'd0);
        chk("rst_add", {47'd0, add_a, add_b, add_cin}, 64'd0);
        chk("rst_u_out", {54'd0, u_out_valid, u_res, u_res_cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {62'd0, in_ready, u_in_ready}, 64'd3);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            issue4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            collect4(r, c, o, lat, seq);
            chk($sformatf("vec%0d_res", i), {32'd0, r}, {32'd0, vecs[i].exp_res});
            chk($sformatf("vec%0d_cout", i), {63'd0, c}, {63'd0, vecs[i].exp_cout});
            chk($sformatf("vec%0d_ovf", i), {63'd0, o}, {63'd0, vecs[i].exp_ovf});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            if (i == 0) chk("vec0_add_a_seq", {32'd0, seq}, 64'h00000000FFFFFFFF);
            release4(0);
        end

        // Backpressure: result held, busy inputs ignored
        issue4(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        collect4(r, c, o, lat, seq);
        chk("bp_res", {32'd0, r}, 64'h33333333);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_a = $urandom; op_b = $urandom; op_sub = ~op_sub; op_cin = ~op_cin;
            @(negedge clk);
            chk("bp_hold_res", {32'd0, res}, 64'h33333333);
            chk("bp_hold_valid_ready", {62'd0, out_valid, in_ready}, 64'd2);
        end
        in_valid = 1'b0;
        release4(0);
        @(negedge clk);
        chk("bp_no_stray_start", {62'd0, out_valid, in_ready}, 64'd1);

        // Reset while k=2 of an operation
        issue4(32'h12345678, 32'h11111111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrun_rst_res", {32'd0, res}, 64'd0);
        chk("midrun_rst_cout_ovf", {62'd0, res_cout, res_ovf}, 64'd0);
        chk("midrun_rst_add", {47'd0, add_a, add_b, add_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrun_rst_ready", {63'd0, in_ready}, 64'd1);
        issue4(32'h00000001, 32'h00000002, 1'b0, 1'b0);
        collect4(r, c, o, lat, seq);
        chk("after_rst_res", {32'd0, r}, 64'h3);
        chk("after_rst_latency", 64'(lat), 64'd4);
        release4(0);

        // Random ops, WORDS=4
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ra, rb;
            logic        rc, rs;
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            model(ra, rb, rc, rs, 32, er, ec, eo);
            issue4(ra, rb, rc, rs);
            collect4(r, c, o, lat, seq);
            chk("rnd4_result", {29'd0, lat == 4, c, o, r}, {29'd0, 1'b1, ec, eo, er});
            release4($urandom_range(0, 3));
        end

        // Random ops, WORDS=1
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            u_op_a = 8'($urandom); u_op_b = 8'($urandom);
            u_op_cin = 1'($urandom_range(0, 1)); u_op_sub = 1'($urandom_range(0, 1));
            model({24'd0, u_op_a}, {24'd0, u_op_b}, u_op_cin, u_op_sub, 8, er, ec, eo);
            u_in_valid = 1'b1;
            n = 0;
            while (!u_in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            @(negedge clk);
            u_in_valid = 1'b0;
            lat = 0;
            while (!u_out_valid && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk("rnd1_result", {53'd0, lat == 1, u_res_cout, u_res_ovf, u_res},
                {53'd0, 1'b1, ec, eo, er[7:0]});
            repeat ($urandom_range(0, 3)) @(negedge clk);
            u_out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            u_out_ready = 1'b0;
            chk("rnd1_idle", {62'd0, u_out_valid, u_in_ready}, 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
